// File: rtl/decode_stage.sv
// decode_stage
//   RV32I instruction decode stage with a DEPTH-entry circular FIFO of
//   decoded entries. Instructions are decoded combinationally as they are
//   accepted; the FIFO head is presented one cycle later (no bypass).
//
//   Build option: define DECODE_MEXT_EN to decode the M extension
//   (opcode 0x33, funct7 0x01 -> alu_op 16+funct3). Without it those
//   encodings are flagged illegal.
//
//   Ports
//     clk, rst      rising-edge clock, synchronous active-high reset
//     flush         discard all buffered entries (drops a same-cycle push)
//     in_valid/in_ready, in_instr, in_pc        instruction input handshake
//     out_valid/out_ready                       head entry handshake
//     out_pc, out_rd, out_rs1, out_rs2, out_imm, out_class,
//     out_alu_op, out_funct3, out_illegal       decoded head entry fields
//
//   Parameters: DEPTH (power of two, >= 2), PC_W, ALU_W.
module decode_stage #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int ALU_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic [3:0]       out_class,
  output logic [ALU_W-1:0] out_alu_op,
  output logic [2:0]       out_funct3,
  output logic             out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [6:0] {
    OP_R      = 7'h33,
    OP_IALU   = 7'h13,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_BRANCH = 7'h63,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_SYSTEM = 7'h73
  } op_e;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_SYSTEM = 4'd9
  } cls_e;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_XOR  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_AND  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_e;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic [3:0]       cls;
    logic [ALU_W-1:0] alu;
    logic [2:0]       f3;
    logic             ill;
  } entry_t;

  // Integer ALU op from funct3; alt selects sub/sra (funct7 bit 5 / instr[30]).
  function automatic alu_e base_alu(input logic [2:0] f3, input logic alt);
    alu_e r;
    r = ALU_ADD;
    case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm;
  cls_e        cls;
  logic [4:0]  alu;
  logic        ill;
  entry_t      dec;

  always_comb begin
    opc   = in_instr[6:0];
    f3    = in_instr[14:12];
    f7    = in_instr[31:25];
    imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
             in_instr[11:8], 1'b0};
    imm_u = {in_instr[31:12], 12'b0};
    imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
             in_instr[30:21], 1'b0};
    imm   = '0;
    cls   = CLS_R;
    alu   = ALU_ADD;
    ill   = 1'b0;
    // Every known opcode ends in 2'b11, so instr[1:0] != 2'b11 lands in default.
    case (opc)
      OP_R: begin
        if (f7 == 7'h00)
          alu = base_alu(f3, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
          alu = base_alu(f3, 1'b1);
`ifdef DECODE_MEXT_EN
        else if (f7 == 7'h01)
          alu = {2'b10, f3};
`endif
        else
          ill = 1'b1;
      end
      OP_IALU: begin
        cls = CLS_IALU;
        imm = imm_i;
        alu = base_alu(f3, (f3 == 3'd5) && in_instr[30]);
      end
      OP_LOAD: begin
        cls = CLS_LOAD;
        imm = imm_i;
        ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OP_STORE: begin
        cls = CLS_STORE;
        imm = imm_s;
        ill = (f3 > 3'd2);
      end
      OP_BRANCH: begin
        cls = CLS_BRANCH;
        imm = imm_b;
        ill = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_JAL: begin
        cls = CLS_JAL;
        imm = imm_j;
      end
      OP_JALR: begin
        cls = CLS_JALR;
        imm = imm_i;
      end
      OP_LUI: begin
        cls = CLS_LUI;
        imm = imm_u;
      end
      OP_AUIPC: begin
        cls = CLS_AUIPC;
        imm = imm_u;
      end
      OP_SYSTEM: begin
        cls = CLS_SYSTEM;
        imm = imm_i;
      end
      default: ill = 1'b1;
    endcase

    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.f3  = f3;
    dec.ill = ill;
    dec.cls = ill ? CLS_R : cls;
    dec.alu = ill ? '0 : ALU_W'(alu);
    dec.imm = ill ? '0 : imm;
  end

  // ------------------------------------------------------------------ FIFO
  entry_t          mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  entry_t          head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Push is gated by the pre-pop full flag: a full FIFO never accepts,
  // even when the head is leaving in the same cycle.
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++)
        mem[i] <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= dec;
        wptr      <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rptr];
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_pc      = head.pc;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_class   = head.cls;
  assign out_alu_op  = head.alu;
  assign out_funct3  = head.f3;
  assign out_illegal = head.ill;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2: decoded-entry buffer depth; power of two, minimum 2.
REQ-002 SHALL have parameter PC_W, default 32: width of the carried program counter.
REQ-003 SHALL have parameter ALU_W, default 5: width of the alu_op field.
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  PC_W  address of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_pc  out  PC_W  carried PC.
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- out_imm  out  32  sign-extended immediate.
- out_class  out  4  0 R, 1 I-alu, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 lui, 8 auipc, 9 system.
- out_alu_op  out  ALU_W  ALU operation.
- out_funct3  out  3  instr[14:12].
- out_illegal  out  1  unrecognised encoding.

Function
REQ-005 SHALL accept an instruction when in_valid and in_ready are both high at a rising edge.
REQ-006 SHALL decode combinationally on the accept edge and store the decoded fields in a DEPTH-entry circular FIFO.
REQ-007 SHALL present out_valid one cycle after an accept into an empty FIFO; there is no same-cycle bypass.
REQ-008 SHALL pop the head when out_valid and out_ready are both high.
REQ-009 SHALL drive in_ready = !full; when full, in_ready stays low even if a pop happens that cycle.
REQ-010 SHALL allow a simultaneous push and pop when neither full nor empty; occupancy is then unchanged.
REQ-011 SHALL wrap read/write pointers modulo DEPTH and keep an occupancy count of width clog2(DEPTH)+1.
REQ-012 SHALL select out_imm by format:
- I: instr[31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- U: {[31:12],12'b0}.
- J: {[31],[19:12],[20],[30:21],0}.
- All except U sign-extended from bit 31.
- R-type: 0.
REQ-013 SHALL encode alu_op as: 0 add, 1 sub, 2 xor, 3 or, 4 and, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
REQ-014 SHALL drive alu_op 0 (add) for load, store, jal, jalr, lui and auipc, and for branches.
REQ-015 SHALL set out_illegal for:
- an unknown opcode;
- unlisted funct3/funct7 combinations (R-type funct7 other than 0x00 or 0x20; 0x20 only for add/srl);
- load funct3 3, 6 or 7;
- store funct3 above 2;
- branch funct3 2 or 3;
- instr[1:0] != 2'b11.
REQ-016 SHALL, for an illegal entry, force out_class 0 and alu_op 0, still buffer it, and pass through PC and register fields.
REQ-017 SHALL, when flush is high, empty the FIFO at the edge and drop any push in that cycle; flush has priority over push and pop.
REQ-018 SHALL hold all out_* fields stable while out_valid is high and out_ready is low.

Reset
REQ-019 SHALL, with rst high at an edge, clear pointers and count, drive out_valid 0 and in_ready 1 from the next cycle, and zero all out_* data fields.
REQ-020 SHALL let rst override flush, push and pop; an in-flight instruction is lost.

Configuration
REQ-021 SHALL, with DECODE_MEXT_EN defined, decode opcode 0x33 with funct7 0x01 as class 0, alu_op 16+funct3 (mul..remu).
REQ-022 SHALL, without DECODE_MEXT_EN, flag those encodings out_illegal, and the M-extension decode logic SHALL be absent.

Verification
REQ-023 SHALL cover: push 0x002081B3 into an empty FIFO -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, class 0, alu_op 0; 0x402081B3 -> alu_op 1.
REQ-024 SHALL cover: 0xFFF00093 (addi x1,x0,-1) -> class 1, imm 0xFFFFFFFF; 0xFE000EE3 (beq, offset -4) -> class 4, imm 0xFFFFFFFC.
REQ-025 SHALL cover: 0x00000000 -> out_illegal=1; 0x022081B3 -> alu_op 16 with DECODE_MEXT_EN, out_illegal=1 without.
REQ-026 SHALL cover: DEPTH=2, out_ready=0, in_valid held high -> two accepts then in_ready=0; raising out_ready drains entries in order with PCs preserved.
REQ-027 SHALL cover: two entries buffered, flush and in_valid high together -> next cycle out_valid=0, count 0, pushed instruction dropped.
REQ-028 SHALL cover: rst asserted for one cycle while the FIFO is full -> out_valid=0, in_ready=1, all fields 0.
